// File: rtl/bus_rr_router.sv
// Multi-bus round-robin packet router: each bus pops its device FIFOs and routes words by ID.
// Latency: pndng sampled at edge t, pop during cycle t+1, push during cycle t+2; 1 word per 3 cycles per bus.
// Backpressure: none downstream; upstream is paced by pop strobes, and a grant is dropped if pndng falls.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   pndng / D_pop            per-port FIFO non-empty flag and head word
//   pop                      one-cycle pop strobe to the granted port
//   push / D_push            one-cycle push strobe(s) and routed word (same word on every port of a bus)
//   busy / drop_cnt          bus FSM not idle / saturating count of invalid-ID words
module bus_rr_router #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter int id_w    = 8,
  parameter logic [id_w-1:0] broadcast = 8'hFF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [bits-1:0][drvrs-1:0]                pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [bits-1:0][drvrs-1:0]                pop,
  output logic [bits-1:0][drvrs-1:0]                push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic [bits-1:0]                           busy,
  output logic [bits-1:0][15:0]                     drop_cnt
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_ROUTE = 2'd2;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_src;
    logic [pckg_sz-1:0] r_word;
    logic [15:0]        r_drop;

    logic               w_any;
    logic [PW-1:0]      w_next;
    int                 w_idx;
    logic [id_w-1:0]    w_id;
    logic               w_valid;
    logic [drvrs-1:0]   w_pop;
    logic [drvrs-1:0]   w_push;

    // Round-robin search: first pending port strictly after the last granted one, wrapping.
    always_comb begin
      w_any  = 1'b0;
      w_next = r_ptr;
      w_idx  = 0;
      for (int i = 1; i <= drvrs; i++) begin
        w_idx = (int'(r_ptr) + i) % drvrs;
        if (!w_any && pndng[b][PW'(w_idx)]) begin
          w_any  = 1'b1;
          w_next = PW'(w_idx);
        end
      end
    end

    assign w_id    = r_word[pckg_sz-1 -: id_w];
    assign w_valid = (int'(w_id) < drvrs) || (w_id == broadcast);

    always_comb begin
      w_pop = '0;
      if (r_state == S_GRANT && pndng[b][r_src]) w_pop[r_src] = 1'b1;
    end

    // Broadcast reaches every port except the source; a unicast may loop back to the source.
    always_comb begin
      w_push = '0;
      if (r_state == S_ROUTE) begin
        if (w_id == broadcast) begin
          w_push        = '1;
          w_push[r_src] = 1'b0;
        end else if (int'(w_id) < drvrs) begin
          w_push[w_id[PW-1:0]] = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_ptr   <= PW'(drvrs - 1);
        r_src   <= '0;
        r_word  <= '0;
        r_drop  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any) begin
              r_src   <= w_next;
              r_state <= S_GRANT;
            end
          end
          S_GRANT: begin
            // A port that withdrew its request loses the grant without moving the pointer.
            if (pndng[b][r_src]) begin
              r_word  <= D_pop[b][r_src];
              r_ptr   <= r_src;
              r_state <= S_ROUTE;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_ROUTE: begin
            if (!w_valid && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign pop[b]      = w_pop;
    assign push[b]     = w_push;
    assign D_push[b]   = {drvrs{r_word}};
    assign busy[b]     = (r_state != S_IDLE);
    assign drop_cnt[b] = r_drop;
  end

endmodule

// File: tb/tb_bus_rr_router.sv
module tb_bus_rr_router;

  localparam int BITS = 2;
  localparam int DRV  = 4;
  localparam int PSZ  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [BITS-1:0][DRV-1:0]          pndng;
  logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_pop;
  logic [BITS-1:0][DRV-1:0]          pop;
  logic [BITS-1:0][DRV-1:0]          push;
  logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_push;
  logic [BITS-1:0]                   busy;
  logic [BITS-1:0][15:0]             drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Device FIFO contents and reference-model state.
  logic [PSZ-1:0] q [BITS][DRV][$];
  int             m_ptr [BITS];
  int             exp_drop [BITS];

  // Per-run observation logs.
  int             grant_log [BITS][$];
  int             push_cyc  [BITS][$];
  logic [DRV-1:0] push_vec  [BITS][$];
  logic [PSZ-1:0] push_dat  [BITS][$];

  bus_rr_router #(
    .bits(BITS), .drvrs(DRV), .pckg_sz(PSZ), .id_w(8), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int b = 0; b < BITS; b++)
      for (int k = 0; k < DRV; k++) begin
        pndng[b][k] = (q[b][k].size() != 0);
        D_pop[b][k] = (q[b][k].size() != 0) ? q[b][k][0] : 16'hDEAD;
      end
  endtask

  // Next grant: first non-empty port after the last granted one, wrapping.
  function automatic int rr_pick(int b);
    for (int i = 1; i <= DRV; i++) begin
      int k = (m_ptr[b] + i) % DRV;
      if (q[b][k].size() != 0) return k;
    end
    return -1;
  endfunction

  function automatic logic [DRV-1:0] route_vec(logic [PSZ-1:0] w, int src);
    int id = int'(w[15:8]);
    if (id < DRV) return DRV'(1 << id);
    if (id == 255) return DRV'(((1 << DRV) - 1) & ~(1 << src));
    return '0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int b = 0; b < BITS; b++)
      for (int k = 0; k < DRV; k++) q[b][k].delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int b = 0; b < BITS; b++) begin
      m_ptr[b]    = DRV - 1;
      exp_drop[b] = 0;
    end
  endtask

  // Plays the preloaded FIFOs into the DUT and checks every cycle against the model.
  // Must be entered just after a rising edge with the buses idle.
  task automatic run_traffic(input int budget);
    logic [PSZ-1:0] pend_word [BITS];
    int             pend_src  [BITS];
    bit             pend_vld  [BITS];
    int             last_pop  [BITS];
    int             take      [BITS];
    int             cyc;
    bit             done;
    for (int b = 0; b < BITS; b++) begin
      pend_vld[b] = 0; last_pop[b] = -1;
      grant_log[b].delete(); push_cyc[b].delete(); push_vec[b].delete(); push_dat[b].delete();
    end
    drive();
    cyc  = 0;
    done = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      for (int b = 0; b < BITS; b++) begin
        logic [DRV-1:0] ev;
        int s;
        ev = pend_vld[b] ? route_vec(pend_word[b], pend_src[b]) : '0;
        n_checks++;
        if (push[b] !== ev) begin
          n_fail++;
          $display("FAIL push bus%0d cyc%0d: got %b want %b", b, cyc, push[b], ev);
        end
        if (pend_vld[b]) begin
          n_checks++;
          if (D_push[b] !== {DRV{pend_word[b]}}) begin
            n_fail++;
            $display("FAIL D_push bus%0d cyc%0d: got %h want %h on all ports", b, cyc, D_push[b], pend_word[b]);
          end
          if (ev == '0) exp_drop[b]++;
          push_cyc[b].push_back(cyc);
          push_vec[b].push_back(push[b]);
          push_dat[b].push_back(D_push[b][0]);
          pend_vld[b] = 0;
        end
        take[b] = -1;
        if (pop[b] !== '0) begin
          s = rr_pick(b);
          n_checks++;
          if (s < 0 || pop[b] !== DRV'(1 << s)) begin
            n_fail++;
            $display("FAIL pop bus%0d cyc%0d: got %b want port %0d", b, cyc, pop[b], s);
          end
          n_checks++;
          if (last_pop[b] < 0 ? (cyc != 1) : (cyc - last_pop[b] != 3)) begin
            n_fail++;
            $display("FAIL pop_timing bus%0d: pop at cyc%0d, previous %0d", b, cyc, last_pop[b]);
          end
          if (s >= 0) begin
            pend_vld[b] = 1; pend_word[b] = q[b][s][0]; pend_src[b] = s;
            m_ptr[b] = s; take[b] = s;
            grant_log[b].push_back(s);
          end
          last_pop[b] = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < BITS; b++)
        if (take[b] >= 0) void'(q[b][take[b]].pop_front());
      drive();
      cyc++;
      done = (busy == '0);
      for (int b = 0; b < BITS; b++) begin
        if (pend_vld[b]) done = 0;
        for (int k = 0; k < DRV; k++) if (q[b][k].size() != 0) done = 0;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL run_timeout: not drained after %0d cycles, busy=%b", cyc, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pop !== '0)      begin n_fail++; $display("FAIL reset_pop: got %h want 0", pop); end
    n_checks++; if (push !== '0)     begin n_fail++; $display("FAIL reset_push: got %h want 0", push); end
    n_checks++; if (D_push !== '0)   begin n_fail++; $display("FAIL reset_D_push: got %h want 0", D_push); end
    n_checks++; if (busy !== '0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop: got %h want 0", drop_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    q[0][1].push_back(16'h0202);
    run_traffic(50);
    n_checks++;
    if (push_cyc[0].size() != 1 || push_cyc[0][0] != 2 || push_vec[0][0] !== 4'b0100 || push_dat[0][0] !== 16'h0202) begin
      n_fail++;
      $display("FAIL single: %0d pushes, first cyc %0d vec %b dat %h; want cyc 2 vec 0100 dat 0202",
               push_cyc[0].size(), push_cyc[0].size() ? push_cyc[0][0] : -1,
               push_vec[0].size() ? push_vec[0][0] : 4'bx, push_dat[0].size() ? push_dat[0][0] : 16'hx);
    end
  endtask

  task automatic test_fairness();
    int exp_g [4] = '{0, 3, 0, 3};
    do_reset();
    q[0][0].push_back(16'h0101); q[0][0].push_back(16'h0202);
    q[0][3].push_back(16'h0303); q[0][3].push_back(16'h0000);
    run_traffic(60);
    n_checks++;
    if (grant_log[0].size() != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants want 4", grant_log[0].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grant_log[0][i] != exp_g[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got port %0d want %0d", i, grant_log[0][i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_broadcast();
    do_reset();
    q[0][2].push_back(16'hFF55);
    run_traffic(50);
    n_checks++;
    if (push_vec[0].size() != 1 || push_vec[0][0] !== 4'b1011 || push_dat[0][0] !== 16'hFF55) begin
      n_fail++;
      $display("FAIL broadcast: %0d routes, vec %b dat %h; want vec 1011 dat FF55", push_vec[0].size(),
               push_vec[0].size() ? push_vec[0][0] : 4'bx, push_dat[0].size() ? push_dat[0][0] : 16'hx);
    end
  endtask

  task automatic test_drop();
    do_reset();
    q[0][0].push_back(16'h0711);
    run_traffic(50);
    n_checks++;
    if (push_vec[0].size() != 1 || push_vec[0][0] !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_push: %0d routes, vec %b; want one route with no push", push_vec[0].size(),
               push_vec[0].size() ? push_vec[0][0] : 4'bx);
    end
    n_checks++; if (drop_cnt[0] !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy[0]); end
  endtask

  task automatic test_reset_mid_route();
    do_reset();
    q[0][1].push_back(16'h0133);
    drive();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (pop[0] !== 4'b0010) begin n_fail++; $display("FAIL mid_pop: got %b want 0010", pop[0]); end
    @(posedge clk);
    #1;
    void'(q[0][1].pop_front());
    drive();
    n_checks++;
    if (push[0] !== 4'b0010 || D_push[0][0] !== 16'h0133) begin
      n_fail++;
      $display("FAIL mid_route: push %b dat %h; want 0010 0133", push[0], D_push[0][0]);
    end
    reset = 1'b1;
    #1;
    n_checks++; if (push[0] !== '0) begin n_fail++; $display("FAIL mid_reset_push: got %b want 0", push[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy[0]); end
    n_checks++; if (drop_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL mid_reset_drop: got %0d want 0", drop_cnt[0]); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int b = 0; b < BITS; b++) begin m_ptr[b] = DRV - 1; exp_drop[b] = 0; end
    q[0][0].push_back(16'h0011);
    q[0][2].push_back(16'h0222);
    run_traffic(50);
    n_checks++;
    if (grant_log[0].size() == 0 || grant_log[0][0] != 0) begin
      n_fail++;
      $display("FAIL mid_next_grant: got port %0d want 0", grant_log[0].size() ? grant_log[0][0] : -1);
    end
  endtask

  task automatic test_two_buses();
    do_reset();
    q[0][1].push_back(16'h0344);
    q[1][0].push_back(16'h0255);
    run_traffic(50);
    n_checks++;
    if (push_cyc[0].size() != 1 || push_cyc[1].size() != 1 ||
        push_cyc[0][0] != 2 || push_cyc[1][0] != 2 ||
        push_vec[0][0] !== 4'b1000 || push_vec[1][0] !== 4'b0100) begin
      n_fail++;
      $display("FAIL two_bus: bus0 %0d routes vec %b, bus1 %0d routes vec %b; want 1000 and 0100 both at cyc 2",
               push_cyc[0].size(), push_vec[0].size() ? push_vec[0][0] : 4'bx,
               push_cyc[1].size(), push_vec[1].size() ? push_vec[1][0] : 4'bx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int round = 0; round < 4; round++) begin
      for (int b = 0; b < BITS; b++)
        for (int k = 0; k < DRV; k++) begin
          int n = $urandom_range(0, 4);
          for (int j = 0; j < n; j++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] id;
            logic [7:0] pl;
            if (r < 6)      id = 8'(r % DRV);
            else if (r < 8) id = 8'hFF;
            else            id = 8'($urandom_range(DRV, 254));
            pl = 8'($urandom);
            q[b][k].push_back({id, pl});
          end
        end
      run_traffic(400);
      for (int b = 0; b < BITS; b++) begin
        n_checks++;
        if (drop_cnt[b] !== 16'(exp_drop[b])) begin
          n_fail++;
          $display("FAIL rand_drop bus%0d round%0d: got %0d want %0d", b, round, drop_cnt[b], exp_drop[b]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_broadcast();
    test_drop();
    test_reset_mid_route();
    test_two_buses();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
